cam_lane_align: RTL and testbench
=================================

# cam_lane_align

Parametrised bit-alignment trainer for the camera LVDS receive path. One instance serves `NUM_CAMS` imagers, each with `NUM_LANES` data lanes plus one sync lane. Each camera deserialises its lanes by `DES`. During sensor training, the block pulses per-lane bitslip until every lane presents `TRAIN_WORD`, then reports aligned or failed status per camera. It sits between the LVDS deserialisers (after lane-inversion correction) and `top`, and replaces the manual PIO-driven bitslip control.

## Interface
- `NUM_CAMS`, 2, number of cameras (independent channels)
- `NUM_LANES`, 4, data lanes per camera; the sync lane is extra and always present
- `DES`, 8, deserialisation factor (bits per lane word)
- `TRAIN_WORD`, 8'h3A, training word expected on every lane (width `DES`)
- `SETTLE_CYCLES`, 16, wait after start/slip before sampling (≥2)
- `MATCH_COUNT`, 64, length of the check window in cycles (≥1)
- `MAX_SLIPS`, 2*DES, per-lane slip limit before failure
- `c`  in  1  clock. One clock; all inputs are synchronous to `c`. Reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  NUM_CAMS  1-cycle pulse per camera; begins or restarts training
- `rx_locked`  in  NUM_CAMS  deserialiser PLL lock per camera
- `rxd`  in  NUM_CAMS*(NUM_LANES+1)*DES  lane words. Lane l of cam k is at `rxd[(k*(NUM_LANES+1)+l)*DES +: DES]`; l=NUM_LANES is the sync lane.
- `bitslip`  out  NUM_CAMS*(NUM_LANES+1)  1-cycle slip pulse per lane; same index order as `rxd`
- `aligned`  out  NUM_CAMS  camera trained and locked
- `fail`  out  NUM_CAMS  training failed or lock lost
- `busy`  out  NUM_CAMS  training in progress

## Operation
- Each camera runs its own FSM with states IDLE, SETTLE, CHECK, SLIP, DONE and FAIL. Cameras never interact.
- IDLE: all outputs are 0.
  - `start` with `rx_locked`=1 → SETTLE, clearing all lane slip counters.
  - `start` with `rx_locked`=0 → FAIL.
- SETTLE: count `SETTLE_CYCLES` cycles, then → CHECK.
- CHECK: lasts exactly `MATCH_COUNT` cycles. A lane is good only if its word equals `TRAIN_WORD` on every cycle of the window. At the end of the window:
  - all lanes good → DONE;
  - any bad lane with slip count = `MAX_SLIPS` → FAIL;
  - otherwise → SLIP.
- SLIP: one cycle. `bitslip`=1 for every bad lane, and those lanes' slip counts increment. Then → SETTLE.
- DONE: `aligned`=1. No further monitoring of lane data.
- FAIL: `fail`=1. It holds until `start` or reset.
- `busy`=1 in SETTLE, CHECK and SLIP.
- Loss of lock: `rx_locked`=0 in SETTLE, CHECK, SLIP or DONE → FAIL on the next cycle. This has priority over `start` and over window evaluation.
- `start` in any state other than IDLE restarts training, following the IDLE rules above. Counters are cleared.
- Slip counters are `$clog2(MAX_SLIPS+1)` bits wide. The window and settle counters are sized by `$clog2`. No counter wraps.

## Timing
- All outputs are registered. `aligned`, `fail` and `busy` decode from the state register. `bitslip` is registered and high only in SLIP.
- Every output resets to 0. A reset mid-training drives every output to 0 the cycle after `rst_n` is sampled low; any in-flight slip pulse is truncated.
- Take `start` as sampled at cycle 0 and write S=`SETTLE_CYCLES`, M=`MATCH_COUNT`:
  - SETTLE occupies cycles 1..S;
  - CHECK occupies S+1..S+M;
  - the outcome state is entered at cycle S+M+1;
  - each slip iteration adds S+M+1 cycles.
- Consecutive slip pulses on one lane are separated by at least S+M low cycles, which satisfies the deserialiser's edge-triggered slip.

## Structure
- Package `cam_align_pkg` holds:
  - the state enum;
  - a lane-index function `lane_idx(k,l)`;
  - `$clog2`-derived width localparams.
- Sub-module `cam_lane_align_ch` contains one camera FSM with its NUM_LANES+1 lane match flags and slip counters. The top level is a generate loop over `NUM_CAMS` plus bus slicing.

## Test plan
All scenarios use default parameters (S=16, M=64). The bench models bitslip as a 1-bit rotate per pulse, with 2 cycles of effect latency.
- Reset release, no stimulus → all outputs 0 for 200 cycles.
- Both cams aligned, `start`=2'b11 at cycle 0 → `aligned`=2'b11 at cycle 81, zero `bitslip` pulses, `busy` high over cycles 1..80.
- Cam1 lane 2 pre-rotated by 3 bits, start both → exactly 3 pulses on `bitslip[7]` and none elsewhere. `aligned[0]` at cycle 81, `aligned[1]` at cycle 324.
- Cam0 sync lane stuck at 8'h00 → 16 pulses on `bitslip[4]`, then `fail[0]` at cycle 1377 with `aligned[0]`=0.
- `rx_locked[1]` dropped at cycle 40 (during CHECK) → `fail[1]` at cycle 41, no `bitslip` on cam1. Cam0 is unaffected.
- `start[0]` pulsed while in DONE → `aligned[0]` falls the next cycle and rises again 81 cycles after that `start`. A reset at the midpoint of a second run → all outputs 0 next cycle.

Source files
------------

// File: rtl/cam_lane_align_pkg.sv
// rtl/cam_lane_align_pkg.sv - shared types, defaults and helpers for the camera lane aligner
package cam_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAIL   = 3'd5
  } align_state_t;

  localparam int DEF_NUM_CAMS   = 2;
  localparam int DEF_NUM_LANES  = 4;
  localparam int DEF_DES        = 8;
  localparam int DEF_SETTLE     = 16;
  localparam int DEF_MATCH      = 64;
  localparam int DEF_MAX_SLIPS  = 2 * DEF_DES;

  // Never returns zero, so a count of one still yields a legal 1-bit register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Flat lane position of lane l of camera k; the sync lane is l == num_lanes.
  function automatic int lane_idx(input int k, input int l, input int num_lanes = DEF_NUM_LANES);
    return k * (num_lanes + 1) + l;
  endfunction

endpackage

// File: rtl/cam_lane_align_if.sv
// rtl/cam_lane_align_if.sv - lane data, control and status bundle between deserialisers and aligner
interface cam_lane_align_if #(
  parameter int NUM_CAMS  = 2,
  parameter int NUM_LANES = 4,
  parameter int DES       = 8
);
  localparam int LANES = NUM_CAMS * (NUM_LANES + 1);

  logic [NUM_CAMS-1:0]  start;
  logic [NUM_CAMS-1:0]  rx_locked;
  logic [LANES*DES-1:0] rxd;
  logic [LANES-1:0]     bitslip;
  logic [NUM_CAMS-1:0]  aligned;
  logic [NUM_CAMS-1:0]  fail;
  logic [NUM_CAMS-1:0]  busy;

  modport master (
    output start, rx_locked, rxd,
    input  bitslip, aligned, fail, busy
  );

  modport slave (
    input  start, rx_locked, rxd,
    output bitslip, aligned, fail, busy
  );
endinterface

// File: rtl/cam_lane_align_ch.sv
// rtl/cam_lane_align_ch.sv - one camera's training FSM with per-lane match flags and slip counters
module cam_lane_align_ch
  import cam_align_pkg::*;
#(
  parameter int              NUM_LANES     = DEF_NUM_LANES,
  parameter int              DES           = DEF_DES,
  parameter logic [DES-1:0]  TRAIN_WORD    = 8'h3A,
  parameter int              SETTLE_CYCLES = DEF_SETTLE,
  parameter int              MATCH_COUNT   = DEF_MATCH,
  parameter int              MAX_SLIPS     = 2 * DES
) (
  input  logic                         c,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         rx_locked,
  input  logic [(NUM_LANES+1)*DES-1:0] rxd,
  output logic [NUM_LANES:0]           bitslip,
  output logic                         aligned,
  output logic                         fail,
  output logic                         busy
);

  localparam int NL     = NUM_LANES + 1;
  localparam int SET_W  = cnt_width(SETTLE_CYCLES);
  localparam int WIN_W  = cnt_width(MATCH_COUNT);
  localparam int SLIP_W = cnt_width(MAX_SLIPS + 1);

  align_state_t      state_q;
  align_state_t      state_d;
  logic [SET_W-1:0]  settle_cnt_q;
  logic [WIN_W-1:0]  win_cnt_q;
  logic [SLIP_W-1:0] slip_cnt_q [NL];
  logic [NL-1:0]     good_q;
  logic [NL-1:0]     bitslip_q;
  logic [NL-1:0]     lane_match;
  logic [NL-1:0]     at_limit;
  logic [NL-1:0]     good_now;
  logic [NL-1:0]     bad_now;
  logic              settle_done;
  logic              win_done;

  always_comb begin
    lane_match = '0;
    at_limit   = '0;
    for (int l = 0; l < NL; l++) begin
      lane_match[l] = (rxd[l*DES +: DES] == TRAIN_WORD);
      at_limit[l]   = (slip_cnt_q[l] == SLIP_W'(MAX_SLIPS));
    end
  end

  // good_q holds the window history; folding in this cycle's match lets the
  // last window cycle count without an extra evaluation cycle.
  assign good_now    = good_q & lane_match;
  assign bad_now     = ~good_now;
  assign settle_done = (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1));
  assign win_done    = (win_cnt_q == WIN_W'(MATCH_COUNT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (start) state_d = rx_locked ? ST_SETTLE : ST_FAIL;
      end
      default: begin
        // Lock loss outranks both a restart and the window verdict.
        if (!rx_locked) begin
          state_d = ST_FAIL;
        end else if (start) begin
          state_d = ST_SETTLE;
        end else begin
          case (state_q)
            ST_SETTLE: if (settle_done) state_d = ST_CHECK;
            ST_CHECK: begin
              if (win_done) begin
                if (&good_now)                 state_d = ST_DONE;
                else if (|(bad_now & at_limit)) state_d = ST_FAIL;
                else                           state_d = ST_SLIP;
              end
            end
            ST_SLIP: state_d = ST_SETTLE;
            default: state_d = state_q;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge c) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      good_q       <= '1;
      bitslip_q    <= '0;
      for (int l = 0; l < NL; l++) slip_cnt_q[l] <= '0;
    end else begin
      state_q   <= state_d;
      bitslip_q <= '0;
      if (state_d == ST_SETTLE) begin
        settle_cnt_q <= (state_q == ST_SETTLE && !start) ? settle_cnt_q + SET_W'(1) : '0;
      end
      if (state_d == ST_CHECK) begin
        win_cnt_q <= (state_q == ST_CHECK) ? win_cnt_q + WIN_W'(1) : '0;
        good_q    <= (state_q == ST_CHECK) ? good_now : '1;
      end
      if (start) begin
        for (int l = 0; l < NL; l++) slip_cnt_q[l] <= '0;
      end else if (state_d == ST_SLIP) begin
        bitslip_q <= bad_now;
        for (int l = 0; l < NL; l++) begin
          if (bad_now[l]) slip_cnt_q[l] <= slip_cnt_q[l] + SLIP_W'(1);
        end
      end
    end
  end

  assign bitslip = bitslip_q;
  assign aligned = (state_q == ST_DONE);
  assign fail    = (state_q == ST_FAIL);
  assign busy    = (state_q == ST_SETTLE) || (state_q == ST_CHECK) || (state_q == ST_SLIP);

endmodule

// File: rtl/cam_lane_align.sv
// rtl/cam_lane_align.sv - per-camera LVDS bitslip trainer, one independent channel per imager
module cam_lane_align
  import cam_align_pkg::*;
#(
  parameter int              NUM_CAMS      = DEF_NUM_CAMS,
  parameter int              NUM_LANES     = DEF_NUM_LANES,
  parameter int              DES           = DEF_DES,
  parameter logic [DES-1:0]  TRAIN_WORD    = 8'h3A,
  parameter int              SETTLE_CYCLES = DEF_SETTLE,
  parameter int              MATCH_COUNT   = DEF_MATCH,
  parameter int              MAX_SLIPS     = 2 * DES
) (
  input  logic             c,
  input  logic             rst_n,
  cam_lane_align_if.slave  bus
);

  localparam int LW = NUM_LANES + 1;

  logic [NUM_CAMS*LW-1:0] bitslip_w;
  logic [NUM_CAMS-1:0]    aligned_w;
  logic [NUM_CAMS-1:0]    fail_w;
  logic [NUM_CAMS-1:0]    busy_w;

  for (genvar k = 0; k < NUM_CAMS; k++) begin : g_cam
    localparam int BASE = lane_idx(k, 0, NUM_LANES);

    cam_lane_align_ch #(
      .NUM_LANES     (NUM_LANES),
      .DES           (DES),
      .TRAIN_WORD    (TRAIN_WORD),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .MATCH_COUNT   (MATCH_COUNT),
      .MAX_SLIPS     (MAX_SLIPS)
    ) u_ch (
      .c         (c),
      .rst_n     (rst_n),
      .start     (bus.start[k]),
      .rx_locked (bus.rx_locked[k]),
      .rxd       (bus.rxd[BASE*DES +: LW*DES]),
      .bitslip   (bitslip_w[BASE +: LW]),
      .aligned   (aligned_w[k]),
      .fail      (fail_w[k]),
      .busy      (busy_w[k])
    );
  end

  assign bus.bitslip = bitslip_w;
  assign bus.aligned = aligned_w;
  assign bus.fail    = fail_w;
  assign bus.busy    = busy_w;

endmodule

// File: tb/tb_cam_lane_align.sv
// tb/tb_cam_lane_align.sv - scoreboard bench for cam_lane_align with a rotating-lane deserialiser model
module tb_cam_lane_align;

  localparam int NC = 2;
  localparam int NLN = 4;
  localparam int D = 8;
  localparam int S = 16;
  localparam int M = 64;
  localparam int MS = 2 * D;
  localparam int P = S + M + 1;
  localparam int NL = NLN + 1;
  localparam int NT = NC * NL;
  localparam logic [D-1:0] TW = 8'h3A;

  typedef struct {
    int         cyc;
    logic [2:0] st;
  } ev_t;

  logic c = 1'b0;
  logic rst_n = 1'b0;

  cam_lane_align_if #(.NUM_CAMS(NC), .NUM_LANES(NLN), .DES(D)) bus ();

  cam_lane_align #(
    .NUM_CAMS(NC), .NUM_LANES(NLN), .DES(D), .TRAIN_WORD(TW),
    .SETTLE_CYCLES(S), .MATCH_COUNT(M), .MAX_SLIPS(MS)
  ) dut (
    .c     (c),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ev_t        exp_st [NC][$];
  int         exp_slip [NT][$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         mon_start = 32'h7fffffff;
  int         rst_chk = -1;
  int         off [NT];
  int         pend [NT];
  bit         stuck [NT];
  int         tl [NC];
  logic [2:0] prev [NC];

  initial forever #5 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string what, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", what, cyc, act, req);
    end
  endtask

  function automatic logic [D-1:0] rotl(input logic [D-1:0] w, input int n);
    logic [2*D-1:0] d;
    d = {w, w};
    return d[2*D-1-n -: D];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge c);
      #1;
    end
  endtask

  task automatic push_st(input int k, input int t, input logic [2:0] st);
    ev_t e;
    e.cyc = t;
    e.st  = st;
    exp_st[k].push_back(e);
  endtask

  // Deserialiser model: slip pulse seen in cycle p rotates the lane word from cycle p+2.
  initial begin
    logic [NT*D-1:0] w;
    forever begin
      @(posedge c);
      #1;
      for (int b = 0; b < NT; b++) begin
        if (pend[b] == cyc) begin
          off[b]  = (off[b] + D - 1) % D;
          pend[b] = -1;
        end
        w[b*D +: D] = stuck[b] ? '0 : rotl(TW, off[b]);
      end
      bus.rxd = w;
    end
  end

  // Monitor: every status change and every slip pulse must match the head of its queue.
  initial begin
    logic [2:0] st;
    ev_t        e;
    int         ep;
    forever begin
      @(negedge c);
      if (cyc >= mon_start) begin
        for (int k = 0; k < NC; k++) begin
          st = {bus.aligned[k], bus.fail[k], bus.busy[k]};
          if (cyc == rst_chk) begin
            chk(st == 3'b000, "reset_status", st, 0);
            prev[k] = 3'b000;
          end else if (st !== prev[k]) begin
            if (exp_st[k].size() == 0) begin
              chk(1'b0, $sformatf("unexpected_status_cam%0d", k), st, prev[k]);
            end else begin
              e = exp_st[k].pop_front();
              chk(e.cyc == cyc, $sformatf("status_cycle_cam%0d", k), cyc, e.cyc);
              chk(e.st == st, $sformatf("status_value_cam%0d", k), st, e.st);
            end
            prev[k] = st;
          end
        end
        if (cyc == rst_chk) chk(bus.bitslip == '0, "reset_bitslip", bus.bitslip, 0);
        for (int b = 0; b < NT; b++) begin
          if (bus.bitslip[b] && cyc != rst_chk) begin
            pend[b] = cyc + 2;
            if (exp_slip[b].size() == 0) begin
              chk(1'b0, $sformatf("unexpected_bitslip_lane%0d", b), cyc, -1);
            end else begin
              ep = exp_slip[b].pop_front();
              chk(ep == cyc, $sformatf("bitslip_cycle_lane%0d", b), cyc, ep);
            end
          end
        end
      end
    end
  end

  // Reference: lane with offset n needs n slips; a stuck lane never aligns.
  // Training takes (slips+1) iterations of S+M+1 cycles; too many slips means fail.
  task automatic plan(input int k, input int t0, input int tdrop);
    int       need, n, t_end, b, p;
    bit       fails;
    if (!bus.rx_locked[k]) begin
      push_st(k, t0 + 1, 3'b010);
      return;
    end
    need = 0;
    for (int l = 0; l < NL; l++) begin
      b = k * NL + l;
      n = stuck[b] ? MS + 1 : off[b];
      if (n > need) need = n;
    end
    fails = (need > MS);
    t_end = t0 + (fails ? MS + 1 : need + 1) * P;
    for (int l = 0; l < NL; l++) begin
      b = k * NL + l;
      n = stuck[b] ? MS : ((off[b] < MS) ? off[b] : MS);
      for (int i = 1; i <= n; i++) begin
        p = t0 + i * P;
        if (tdrop < 0 || p <= tdrop) exp_slip[b].push_back(p);
      end
    end
    push_st(k, t0 + 1, 3'b001);
    if (tdrop >= 0 && tdrop < t_end) begin
      push_st(k, tdrop + 1, 3'b010);
    end else begin
      push_st(k, t_end, fails ? 3'b010 : 3'b100);
      if (tdrop >= 0 && !fails) push_st(k, tdrop + 1, 3'b010);
    end
  endtask

  task automatic start_run(input logic [NC-1:0] mask, input int rel0, input int rel1);
    int t0;
    t0 = cyc;
    tl[0] = (mask[0] && rel0 > 0) ? t0 + rel0 : -1;
    tl[1] = (mask[1] && rel1 > 0) ? t0 + rel1 : -1;
    for (int k = 0; k < NC; k++) if (mask[k]) plan(k, t0, tl[k]);
    bus.start = mask;
    tick(1);
    bus.start = '0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < NC; k++) if (tl[k] >= 0 && cyc == tl[k]) bus.rx_locked[k] = 1'b0;
      tick(1);
    end
  endtask

  task automatic clean_lanes();
    for (int b = 0; b < NT; b++) begin
      off[b]   = 0;
      stuck[b] = 1'b0;
      pend[b]  = -1;
    end
  endtask

  task automatic do_reset();
    ev_t e;
    int  ep;
    rst_n   = 1'b0;
    rst_chk = cyc + 1;
    if (mon_start == 32'h7fffffff) mon_start = cyc + 1;
    tick(3);
    rst_n = 1'b1;
    bus.rx_locked = '1;
    for (int k = 0; k < NC; k++) begin
      while (exp_st[k].size() > 0) begin
        e = exp_st[k].pop_front();
        if (e.cyc < rst_chk) chk(1'b0, $sformatf("missed_status_cam%0d", k), -1, e.cyc);
      end
    end
    for (int b = 0; b < NT; b++) begin
      while (exp_slip[b].size() > 0) begin
        ep = exp_slip[b].pop_front();
        if (ep < rst_chk) chk(1'b0, $sformatf("missed_bitslip_lane%0d", b), -1, ep);
      end
      pend[b] = -1;
    end
    tl[0] = -1;
    tl[1] = -1;
  endtask

  initial begin
    bus.start     = '0;
    bus.rx_locked = '1;
    tl[0] = -1;
    tl[1] = -1;
    for (int k = 0; k < NC; k++) prev[k] = 3'b000;
    clean_lanes();
    tick(2);
    do_reset();

    for (int i = 0; i < 4; i++) begin
      tick(50);
      chk({bus.aligned, bus.fail, bus.busy, bus.bitslip} == '0, "idle_outputs",
          {bus.aligned, bus.fail, bus.busy, bus.bitslip}, 0);
    end

    clean_lanes();
    tick(2);
    start_run(2'b11, -1, -1);
    run_cycles(100);
    do_reset();

    clean_lanes();
    off[7] = 3;
    tick(2);
    start_run(2'b11, -1, -1);
    run_cycles(340);
    do_reset();

    clean_lanes();
    stuck[4] = 1'b1;
    tick(2);
    start_run(2'b11, -1, -1);
    run_cycles(1400);
    chk(bus.aligned[0] == 1'b0, "stuck_sync_aligned0", bus.aligned[0], 0);
    do_reset();

    clean_lanes();
    tick(2);
    start_run(2'b11, -1, 40);
    run_cycles(120);
    do_reset();

    clean_lanes();
    tick(2);
    start_run(2'b11, -1, -1);
    run_cycles(99);
    start_run(2'b01, -1, -1);
    run_cycles(100);
    start_run(2'b11, -1, -1);
    run_cycles(39);
    do_reset();

    for (int ep = 0; ep < 8; ep++) begin
      logic [NC-1:0] mask;
      clean_lanes();
      for (int b = 0; b < NT; b++) begin
        off[b]   = int'($urandom_range(0, D - 1));
        stuck[b] = ($urandom_range(0, 15) == 0);
      end
      for (int k = 0; k < NC; k++) bus.rx_locked[k] = ($urandom_range(0, 7) != 0);
      mask = NC'($urandom_range(1, 3));
      tick(2);
      start_run(mask,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 700)) : -1,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 700)) : -1);
      run_cycles((MS + 1) * P + 30);
      do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
